// File: rtl/lane_pkg.sv
// Shared types, colour codes and default geometry for the lane scroller.
// Build option: define MAP_GRASS_TEXTURE_EN for the textured grass verge.
package lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_BLACK = 2'd0,
    CLS_ROAD  = 2'd1,
    CLS_DASH  = 2'd2,
    CLS_GRASS = 2'd3
  } pix_cls_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] ROAD  = 3'b001;
  localparam logic [2:0] DASH  = 3'b111;
  localparam logic [2:0] GRASS = 3'b010;

  localparam int DEF_LANES      = 4;
  localparam int DEF_ROAD_LEFT  = 80;
  localparam int DEF_ROAD_RIGHT = 560;
  localparam int DEF_DASH_LEN   = 20;
  localparam int DEF_DASH_GAP   = 20;
  localparam int DEF_SPEED_MAX  = 7;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;

endpackage

// File: rtl/lane_scroll_ctrl.sv
// Per-frame scroll controller: IDLE/RUN/BRAKE, speed, dash offset and grass offset.
// Build option: MAP_GRASS_TEXTURE_EN adds the grass offset register and port.
module lane_scroll_ctrl
  import lane_pkg::*;
#(
  parameter int PERIOD    = DEF_DASH_LEN + DEF_DASH_GAP,
  parameter int SPEED_MAX = DEF_SPEED_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_start,
  input  logic       i_run,
  input  logic       i_speed_up,
  input  logic       i_speed_down,
  output logic [2:0] o_speed,
  output logic [5:0] o_offset
`ifdef MAP_GRASS_TEXTURE_EN
  ,
  output logic [3:0] o_gofs
`endif
);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_speed, w_speed_nxt;
  logic [5:0] r_off,   w_off_nxt;
  logic       w_adv_en;
  logic [6:0] w_adv, w_adv_wrap;

  assign w_adv      = {1'b0, r_off} + {4'b0, r_speed};
  assign w_adv_wrap = (w_adv >= 7'(PERIOD)) ? w_adv - 7'(PERIOD) : w_adv;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    w_off_nxt   = r_off;
    w_adv_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_state_nxt = ST_RUN;
          if (r_speed == 3'd0) w_speed_nxt = 3'd1;
        end
      end
      ST_RUN: begin
        w_adv_en = 1'b1;
        // Dropping run turns this frame into the first braking frame.
        if (!i_run) begin
          w_speed_nxt = r_speed - 3'd1;
          w_state_nxt = (r_speed == 3'd1) ? ST_IDLE : ST_BRAKE;
        end else if (i_speed_up && !i_speed_down) begin
          if (r_speed < 3'(SPEED_MAX)) w_speed_nxt = r_speed + 3'd1;
        end else if (i_speed_down && !i_speed_up) begin
          if (r_speed > 3'd1) w_speed_nxt = r_speed - 3'd1;
        end
      end
      ST_BRAKE: begin
        w_adv_en = 1'b1;
        if (i_run) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_speed_nxt = r_speed - 3'd1;
          if (r_speed == 3'd1) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_adv_en) w_off_nxt = w_adv_wrap[5:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_speed <= 3'd0;
      r_off   <= 6'd0;
    end else if (i_frame_start) begin
      r_state <= w_state_nxt;
      r_speed <= w_speed_nxt;
      r_off   <= w_off_nxt;
    end
  end

`ifdef MAP_GRASS_TEXTURE_EN
  logic [3:0] r_gofs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gofs <= 4'd0;
    end else if (i_frame_start && w_adv_en) begin
      r_gofs <= r_gofs + {2'b00, r_speed[2:1]};
    end
  end

  assign o_gofs = r_gofs;
`endif

  assign o_speed  = r_speed;
  assign o_offset = r_off;

endmodule

// File: rtl/lane_scroller.sv
// Scrolling road renderer: two-stage pixel pipeline fed by lane_scroll_ctrl.
// Build option: MAP_GRASS_TEXTURE_EN selects striped grass instead of solid verge.
module lane_scroller
  import lane_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int ROAD_LEFT  = DEF_ROAD_LEFT,
  parameter int ROAD_RIGHT = DEF_ROAD_RIGHT,
  parameter int DASH_LEN   = DEF_DASH_LEN,
  parameter int DASH_GAP   = DEF_DASH_GAP,
  parameter int SPEED_MAX  = DEF_SPEED_MAX,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       frame_start,
  input  logic       run,
  input  logic       speed_up,
  input  logic       speed_down,
  output logic       Map_R,
  output logic       Map_G,
  output logic       Map_B,
  output logic [2:0] speed,
  output logic [5:0] scroll_off
);

  localparam int         PERIOD = DASH_LEN + DASH_GAP;
  localparam int         LANE_W = (ROAD_RIGHT - ROAD_LEFT) / LANES;
  localparam logic [9:0] X_LEFT = 10'(ROAD_LEFT);
  localparam logic [9:0] X_RGHT = 10'(ROAD_RIGHT);
  localparam logic [9:0] X_MAX  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE);

  logic [3:0] w_gofs;

  lane_scroll_ctrl #(
    .PERIOD    (PERIOD),
    .SPEED_MAX (SPEED_MAX)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_start (frame_start),
    .i_run         (run),
    .i_speed_up    (speed_up),
    .i_speed_down  (speed_down),
    .o_speed       (speed),
    .o_offset      (scroll_off)
`ifdef MAP_GRASS_TEXTURE_EN
    ,
    .o_gofs        (w_gofs)
`endif
  );

`ifndef MAP_GRASS_TEXTURE_EN
  assign w_gofs = 4'd0;
`endif

  logic        w_in_band;
  logic [10:0] w_phase;
  pix_cls_e    w_cls;
  logic [3:0]  w_xy4;

  always_comb begin
    w_in_band = 1'b0;
    for (int k = 1; k < LANES; k++) begin
      if (int'(CounterX) >= ROAD_LEFT + k * LANE_W - 4 &&
          int'(CounterX) <= ROAD_LEFT + k * LANE_W + 3)
        w_in_band = 1'b1;
    end
  end

  // y + PERIOD is kept at 11 bits; offset < PERIOD so the difference never underflows.
  assign w_phase = ({1'b0, CounterY} + 11'(PERIOD) - {5'b0, scroll_off}) % 11'(PERIOD);
  assign w_xy4   = CounterX[3:0] + CounterY[3:0];

  always_comb begin
    w_cls = CLS_ROAD;
    if (CounterX >= X_MAX || CounterY >= Y_MAX)            w_cls = CLS_BLACK;
    else if (CounterX == X_LEFT || CounterX == X_RGHT - 10'd1) w_cls = CLS_BLACK;
    else if (CounterX < X_LEFT || CounterX >= X_RGHT)      w_cls = CLS_GRASS;
    else if (w_in_band && w_phase < 11'(DASH_LEN))         w_cls = CLS_DASH;
  end

  pix_cls_e   r_cls;
  logic [3:0] r_xy4;
  logic [2:0] w_rgb, r_rgb;
  logic [3:0] w_tex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls <= CLS_BLACK;
      r_xy4 <= 4'd0;
    end else begin
      r_cls <= w_cls;
      r_xy4 <= w_xy4;
    end
  end

  assign w_tex = r_xy4 - w_gofs;

  always_comb begin
    w_rgb = BLACK;
    case (r_cls)
      CLS_ROAD:  w_rgb = ROAD;
      CLS_DASH:  w_rgb = DASH;
`ifdef MAP_GRASS_TEXTURE_EN
      CLS_GRASS: w_rgb = (w_tex <= 4'd5) ? GRASS : BLACK;
`else
      CLS_GRASS: w_rgb = GRASS;
`endif
      default:   w_rgb = BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rgb <= BLACK;
    else        r_rgb <= w_rgb;
  end

  assign {Map_R, Map_G, Map_B} = r_rgb;

endmodule

// File: tb/tb_lane_scroller.sv
// Self-checking bench for lane_scroller: pixel vector table, scroll corner sequences,
// and randomized frames compared against a behavioural model.
module tb_lane_scroller;

  localparam int PERIOD = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] CounterX, CounterY;
  logic       frame_start, run, speed_up, speed_down;
  logic       Map_R, Map_G, Map_B;
  logic [2:0] speed;
  logic [5:0] scroll_off;

  lane_scroller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CounterX    (CounterX),
    .CounterY    (CounterY),
    .frame_start (frame_start),
    .run         (run),
    .speed_up    (speed_up),
    .speed_down  (speed_down),
    .Map_R       (Map_R),
    .Map_G       (Map_G),
    .Map_B       (Map_B),
    .speed       (speed),
    .scroll_off  (scroll_off)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 brake.
  int m_mode, m_speed, m_off, m_gofs;

  function automatic void model_reset();
    m_mode = 0; m_speed = 0; m_off = 0; m_gofs = 0;
  endfunction

  function automatic void model_frame(input bit r, input bit u, input bit d);
    if (m_mode == 0) begin
      if (r) begin
        m_mode = 1;
        if (m_speed == 0) m_speed = 1;
      end
    end else begin
      m_off  = (m_off + m_speed) % PERIOD;
      m_gofs = (m_gofs + m_speed / 2) % 16;
      if (!r) begin
        m_speed = m_speed - 1;
        m_mode  = (m_speed == 0) ? 0 : 2;
      end else if (m_mode == 2) begin
        m_mode = 1;
      end else if (u && !d) begin
        m_speed = (m_speed + 1 > 7) ? 7 : m_speed + 1;
      end else if (d && !u) begin
        m_speed = (m_speed - 1 < 1) ? 1 : m_speed - 1;
      end
    end
  endfunction

  function automatic int grass_ref(input int x, input int y, input int g);
`ifdef MAP_GRASS_TEXTURE_EN
    return ((((x + y - g) % 16) + 16) % 16 <= 5) ? 2 : 0;
`else
    return 2;
`endif
  endfunction

  function automatic int ref_pix(input int x, input int y);
    bit band = 0;
    if (x >= 640 || y >= 480) return 0;
    if (x == 80 || x == 559) return 0;
    if (x < 80 || x >= 560) return grass_ref(x, y, m_gofs);
    for (int k = 1; k < 4; k++)
      if (x >= 80 + k * 120 - 4 && x <= 80 + k * 120 + 3) band = 1;
    if (band && ((y + PERIOD - m_off) % PERIOD) < 20) return 7;
    return 1;
  endfunction

  task automatic pix_check(input string name, input int x, input int y, input int exp);
    @(negedge clk);
    CounterX = 10'(x);
    CounterY = 10'(y);
    @(posedge clk);
    @(posedge clk);
    #1 check(name, {29'd0, Map_R, Map_G, Map_B}, 32'(exp));
  endtask

  task automatic frame(input bit r, input bit u, input bit d);
    @(negedge clk);
    run = r; speed_up = u; speed_down = d; frame_start = 1'b1;
    @(posedge clk);
    #1 model_frame(r, u, d);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic ctrl_check(input string name);
    check({name, ".speed"}, {29'd0, speed}, 32'(m_speed));
    check({name, ".off"}, {26'd0, scroll_off}, 32'(m_off));
  endtask

  typedef struct {
    int x;
    int y;
    int exp;
  } pix_vec_t;

  pix_vec_t tbl[16];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; CounterX = '0; CounterY = '0;
    frame_start = 0; run = 0; speed_up = 0; speed_down = 0;
    model_reset();
    #1;
    check("rst.map", {29'd0, Map_R, Map_G, Map_B}, 0);
    check("rst.speed", {29'd0, speed}, 0);
    check("rst.off", {26'd0, scroll_off}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Offset 0 after reset: dash rows are y mod 40 < 20.
    tbl[0]  = '{80, 10, 0};
    tbl[1]  = '{81, 10, 1};
    tbl[2]  = '{559, 10, 0};
    tbl[3]  = '{600, 10, grass_ref(600, 10, 0)};
    tbl[4]  = '{300, 480, 0};
    tbl[5]  = '{640, 10, 0};
    tbl[6]  = '{200, 10, 7};
    tbl[7]  = '{200, 25, 1};
    tbl[8]  = '{196, 0, 7};
    tbl[9]  = '{195, 0, 1};
    tbl[10] = '{203, 39, 1};
    tbl[11] = '{204, 5, 1};
    tbl[12] = '{440, 19, 7};
    tbl[13] = '{444, 19, 1};
    tbl[14] = '{79, 10, grass_ref(79, 10, 0)};
    tbl[15] = '{560, 10, grass_ref(560, 10, 0)};
    for (int i = 0; i < 16; i++)
      pix_check($sformatf("tbl%0d(%0d,%0d)", i, tbl[i].x, tbl[i].y), tbl[i].x, tbl[i].y, tbl[i].exp);

    // Start from IDLE: first frame loads speed 1, next advances offset.
    frame(1, 0, 0);
    check("start.speed", {29'd0, speed}, 1);
    check("start.off0", {26'd0, scroll_off}, 0);
    frame(1, 0, 0);
    check("start.off1", {26'd0, scroll_off}, 1);
    pix_check("start.dash", 200, 1, 7);
    pix_check("start.road", 200, 0, 1);

    // frame_start with a pixel in flight: that pixel uses the old offset.
    @(negedge clk);
    CounterX = 10'd200; CounterY = 10'd1; run = 1; frame_start = 1'b1;
    @(posedge clk);
    #1 model_frame(1, 0, 0);
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #1 check("midpipe.old", {29'd0, Map_R, Map_G, Map_B}, 7);
    @(posedge clk);
    #1 check("midpipe.new", {29'd0, Map_R, Map_G, Map_B}, 1);

    repeat (10) frame(1, 1, 0);
    check("sat.speed", {29'd0, speed}, 7);
    frame(1, 1, 1);
    check("both.speed", {29'd0, speed}, 7);
    ctrl_check("both");
    repeat (4) frame(1, 0, 1);
    check("down.speed", {29'd0, speed}, 3);

    for (int i = 0; i < 45 && m_off != 38; i++) frame(1, 0, 0);
    check("reach38", {26'd0, scroll_off}, 38);
    frame(1, 0, 0);
    check("wrap.off", {26'd0, scroll_off}, 1);
    check("wrap.speed", {29'd0, speed}, 3);

    frame(0, 0, 0);
    check("brk1.speed", {29'd0, speed}, 2);
    check("brk1.off", {26'd0, scroll_off}, 4);
    frame(0, 0, 0);
    check("brk2.speed", {29'd0, speed}, 1);
    check("brk2.off", {26'd0, scroll_off}, 6);
    frame(0, 0, 0);
    check("brk3.speed", {29'd0, speed}, 0);
    check("brk3.off", {26'd0, scroll_off}, 7);
    frame(0, 1, 0);
    check("idle.speed", {29'd0, speed}, 0);
    check("idle.off", {26'd0, scroll_off}, 7);

    // Asynchronous reset in the middle of a frame with a dash on screen.
    frame(1, 0, 0);
    pix_check("prerst.dash", 200, 10, 7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst.map", {29'd0, Map_R, Map_G, Map_B}, 0);
    check("midrst.speed", {29'd0, speed}, 0);
    check("midrst.off", {26'd0, scroll_off}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 250; f++) begin
      frame($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      ctrl_check($sformatf("rnd%0d", f));
      for (int p = 0; p < 2; p++) begin
        int x, y;
        x = (p == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 511));
        pix_check($sformatf("rndpix%0d(%0d,%0d)", f, x, y), x, y, ref_pix(x, y));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
